data_sram_responder: RTL
========================

# data_sram_responder

Responder (slave) end of the core's data-side SRAM-like interface: accepts `req`/`addr_ok` address-phase handshakes from the pipeline's EXE/MEM initiator and returns strictly in-order `data_ok`/`rdata` responses after a configurable latency. It is backed by a word-addressed behavioural memory with byte-strobe writes. It serves as the simulation/FPGA data memory for the pipeline and as the reference responder for verifying the MEM stage's `data_ok` wait logic.

## Interface
- `ADDR_W`, default 12: word-index width; memory holds 2^ADDR_W 32-bit words.
- `LAT`, default 2, legal range 0..7: extra response delay in cycles.
- `QDEPTH`, default 2, power of two ≥ 2: maximum number of outstanding accepted requests.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `data_sram_req` in 1: request valid.
- `data_sram_wr` in 1: 1 = write, 0 = read.
- `data_sram_size` in 2: 0 = byte, 1 = half, 2 = word. Informational only.
- `data_sram_wstrb` in 4: byte enables for a write.
- `data_sram_addr` in 32: byte address.
- `data_sram_wdata` in 32: write data.
- `addr_stall` in 1: test hook; when 1, forces `addr_ok` low.
- `data_sram_addr_ok` out 1: address phase accepted this cycle.
- `data_sram_data_ok` out 1: response for the oldest outstanding request.
- `data_sram_rdata` out 32: read data, valid only while `data_ok`=1.

## Operation
- **Accept.** A request is accepted when `req && addr_ok` in the same cycle.
  - `addr_ok = (count < QDEPTH) && !addr_stall`.
  - `addr_ok` does not depend combinationally on `req` or on `data_ok`; a full queue stalls even if the head retires that cycle.
- **Addressing.** Word index is `addr[ADDR_W+1:2]`. Upper bits are ignored, so addresses alias. The low two bits are ignored for the word select.
- **Write.** Commits at the acceptance edge: byte lane i of the word is updated iff `wstrb[i]`. A write with `wstrb`=0 modifies nothing but still queues a response.
- **Read.** Samples the memory word at acceptance, before any write accepted in the same cycle; only one request can be accepted per cycle anyway. The full 32-bit word is returned, and lane extraction is the initiator's job.
  - Because writes commit and reads sample at acceptance, read-after-write through the queue is always coherent.
- **Queue.** Accepted request pushes entry {wr, rdata, cnt=LAT} at tail.
  - Each cycle, every valid entry with cnt>0 decrements.
  - Head entry with cnt==0 drives `data_ok`=1, and `rdata`=entry.rdata for a read or 32'h0 for a write. It pops at that edge.
  - Exactly one response per accepted request, in acceptance order, at most one per cycle.
- **Simultaneous push and pop** in the same cycle: count is unchanged, and both pointers advance modulo QDEPTH.
- **`size`** is not checked. Misalignment is the initiator's responsibility and is handled by its exception logic.

## Timing
- **Reset.** While `resetn`=0, asynchronously:
  - queue empty, head = tail = count = 0;
  - `data_ok`=0 and `rdata`=0;
  - `addr_ok` follows `!addr_stall`, so it is 1 out of reset.
- **Memory after reset.** Contents are not reset; they may be preloaded by the bench. Requests in flight when `resetn` falls are discarded and never get a `data_ok`.
- **Latency.** A request accepted at edge E gives `data_ok` high in the cycle after edge E+LAT when the queue ahead is empty.
  - LAT=0 gives `data_ok` the cycle right after acceptance.
- **Throughput.** Back-to-back accepts give back-to-back `data_ok`s. Sustained 1 request/cycle requires QDEPTH ≥ LAT+1; otherwise `addr_ok` throttles.
- **Output sources.** `data_ok` and `rdata` are decoded from registered head state only, with no combinational path from any input. `addr_ok` depends combinationally only on `count` and `addr_stall`.

## Structure
- **Package `data_sram_resp_pkg`:**
  - struct `resp_entry_t` {wr, rdata[31:0], cnt[2:0]};
  - size encodings `SIZE_B`/`SIZE_H`/`SIZE_W`;
  - `LAT_MAX`=7.
- **Sub-module `resp_fifo`:** a QDEPTH-entry FIFO of `resp_entry_t` holding head/tail/count, with per-entry countdown and head-ready output.
- **Top level:** the memory array, strobe merge, and accept logic.

## Test plan
- **Write then read.** LAT=2: write addr 0x10, wdata 0xDEADBEEF, wstrb 4'hF, then read 0x10 next cycle → two `data_ok`s 3 cycles after each accept; the read returns 0xDEADBEEF and the write returns rdata 0.
- **Byte strobes.** Word 0x20 = 0x11223344; write wdata 0xAABBCCDD, wstrb 4'b0101; read → 0x11BB33DD.
- **Queue full.** LAT=7, QDEPTH=2, `req` held high for 4 reads → `addr_ok` drops after 2 accepts and rises only the cycle after the first `data_ok`; responses come in order.
- **Zero latency streaming.** LAT=0, QDEPTH=2, 8 consecutive reads of ascending words → `addr_ok` stays 1 and `data_ok` is high 8 consecutive cycles, each one cycle after its accept.
- **Stall hook.** `addr_stall`=1 for 5 cycles with `req`=1 → no accept and no `data_ok`; on release, accept on the first cycle.
- **Reset mid-flight.** Deassert `resetn` asynchronously with 2 reads outstanding → `data_ok` goes 0 immediately, count 0; after release no stale `data_ok` appears and a new read completes normally.

Source files
------------

// File: rtl/data_sram_responder_pkg.sv
// Shared types and constants for the data-side SRAM responder:
// response queue entry layout, size encodings and the byte-strobe merge helper.
package data_sram_resp_pkg;

   localparam int LAT_MAX = 7;

   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;

   typedef struct packed {
      logic        wr;
      logic [31:0] rdata;
      logic [2:0]  cnt;
   } resp_entry_t;

   function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// Data-side SRAM-like bus between the pipeline initiator (master) and a responder (slave).
interface data_sram_responder_if;

   logic        data_sram_req;
   logic        data_sram_wr;
   logic [1:0]  data_sram_size;
   logic [3:0]  data_sram_wstrb;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic        data_sram_addr_ok;
   logic        data_sram_data_ok;
   logic [31:0] data_sram_rdata;

   modport master (
      output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
             data_sram_addr, data_sram_wdata,
      input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

   modport slave (
      input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
             data_sram_addr, data_sram_wdata,
      output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
   );

endinterface

// File: rtl/data_sram_responder_fifo.sv
// In-order response queue: each entry counts down its latency and the head
// retires (data_ok) once its countdown reaches zero.
module resp_fifo
   import data_sram_resp_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push,
   input  resp_entry_t              push_entry,
   output logic [$clog2(QDEPTH):0]  count,
   output logic                     data_ok,
   output logic [31:0]              rdata
);

   localparam int PW = $clog2(QDEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);
   localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);

   resp_entry_t       entry_r [QDEPTH];
   logic [QDEPTH-1:0] valid_r;
   logic [PW-1:0]     head_r;
   logic [PW-1:0]     tail_r;
   logic [PW:0]       count_r;
   resp_entry_t       head_s;
   logic              pop_s;

   assign head_s = entry_r[head_r];
   assign pop_s  = valid_r[head_r] && (head_s.cnt == 3'd0);
   assign count  = count_r;

   // Queue state: per-entry countdown, pop at head, push at tail.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < QDEPTH; i++) begin
            entry_r[i] <= '0;
         end
         valid_r <= '0;
         head_r  <= '0;
         tail_r  <= '0;
         count_r <= '0;
      end else begin
         for (int i = 0; i < QDEPTH; i++) begin
            if (valid_r[i] && (entry_r[i].cnt != 3'd0)) begin
               entry_r[i].cnt <= entry_r[i].cnt - 3'd1;
            end
         end
         if (pop_s) begin
            valid_r[head_r] <= 1'b0;
            head_r          <= head_r + PTR_ONE;
         end
         // The tail slot is never valid when pushed, so it cannot clash with the countdown.
         if (push) begin
            entry_r[tail_r] <= push_entry;
            valid_r[tail_r] <= 1'b1;
            tail_r          <= tail_r + PTR_ONE;
         end
         case ({push, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

   // Response decode from registered head state only; writes return zero.
   always_comb begin
      if (pop_s) begin
         data_ok = 1'b1;
         rdata   = head_s.wr ? 32'h0000_0000 : head_s.rdata;
      end else begin
         data_ok = 1'b0;
         rdata   = 32'h0000_0000;
      end
   end

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: word-addressed memory with byte-strobe writes that
// commit at acceptance, and in-order responses after a fixed latency.
module data_sram_responder
   import data_sram_resp_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int LAT    = 2,
   parameter int QDEPTH = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  addr_stall,
   data_sram_responder_if.slave  bus
);

   localparam int CW = $clog2(QDEPTH) + 1;
   localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

   logic [31:0]       mem_r [2**ADDR_W];
   logic [ADDR_W-1:0] word_idx_s;
   logic [31:0]       rd_word_s;
   logic [CW-1:0]     count_s;
   logic              addr_ok_s;
   logic              accept_s;
   resp_entry_t       push_entry_s;
   logic              unused_bits_s;

   // Upper address bits alias and the byte offset is the initiator's concern.
   assign word_idx_s    = bus.data_sram_addr[ADDR_W+1:2];
   assign unused_bits_s = &{1'b0, bus.data_sram_size,
                            bus.data_sram_addr[31:ADDR_W+2], bus.data_sram_addr[1:0]};

   assign addr_ok_s             = (count_s < QFULL) && !addr_stall;
   assign bus.data_sram_addr_ok = addr_ok_s;
   assign accept_s              = bus.data_sram_req && addr_ok_s;
   assign rd_word_s             = mem_r[word_idx_s];

   // Build the queue entry; reads capture the word as it was before this edge.
   always_comb begin
      push_entry_s.wr  = bus.data_sram_wr;
      push_entry_s.cnt = 3'(LAT);
      if (bus.data_sram_wr) begin
         push_entry_s.rdata = 32'h0000_0000;
      end else begin
         push_entry_s.rdata = rd_word_s;
      end
   end

   // Memory contents survive reset; writes commit on the acceptance edge.
   always_ff @(posedge clk) begin
      if (accept_s && bus.data_sram_wr && resetn) begin
         mem_r[word_idx_s] <= strb_merge(rd_word_s, bus.data_sram_wdata, bus.data_sram_wstrb);
      end
   end

   resp_fifo #(
      .QDEPTH (QDEPTH)
   ) u_fifo (
      .clk        (clk),
      .resetn     (resetn),
      .push       (accept_s),
      .push_entry (push_entry_s),
      .count      (count_s),
      .data_ok    (bus.data_sram_data_ok),
      .rdata      (bus.data_sram_rdata)
   );

endmodule
